// File: rtl/arcade_input_mapper_if.sv
// Player-control bundle between the hps_io side and the game core pins.
interface arcade_input_mapper_if #(
    parameter int unsigned PLAYERS = 2
);
    logic [10:0]             ps2_key;
    logic [16*PLAYERS-1:0]   joy_in;
    logic                    joy_share;
    logic                    autofire_en;
    logic [PLAYERS-1:0]      up;
    logic [PLAYERS-1:0]      down;
    logic [PLAYERS-1:0]      left;
    logic [PLAYERS-1:0]      right;
    logic [PLAYERS-1:0]      fire;
    logic [PLAYERS-1:0]      start;
    logic [PLAYERS-1:0]      coin;

    // Input side: keyboard/joystick source.
    modport master (
        output ps2_key, joy_in, joy_share, autofire_en,
        input  up, down, left, right, fire, start, coin
    );

    // Mapper side.
    modport slave (
        input  ps2_key, joy_in, joy_share, autofire_en,
        output up, down, left, right, fire, start, coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Arcade player-input front end: PS/2 key state + joystick merge, direction
// cleaning, fixed-width coin pulses and optional autofire.
module arcade_input_mapper #(
    parameter int unsigned PLAYERS      = 2,
    parameter int unsigned COIN_PULSE   = 16,
    parameter int unsigned AUTOFIRE_DIV = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    arcade_input_mapper_if.slave ctrl_io
);
    localparam int unsigned CoinW = $clog2(COIN_PULSE + 1);
    localparam int unsigned AfW   = $clog2(AUTOFIRE_DIV + 1);
    localparam logic [CoinW-1:0] CoinLoad = CoinW'(COIN_PULSE);
    localparam logic [AfW-1:0]   AfLast   = AfW'(AUTOFIRE_DIV - 1);

    logic       old_toggle_q;
    logic       ps2_event;
    logic       ps2_pressed;
    logic       ps2_ext;
    logic [7:0] ps2_code;

    // Directions/fire only have keys for players 0 and 1.
    logic [1:0] key_up_q, key_up_d;
    logic [1:0] key_down_q, key_down_d;
    logic [1:0] key_left_q, key_left_d;
    logic [1:0] key_right_q, key_right_d;
    logic [1:0] key_fire_q, key_fire_d;
    logic [3:0] key_start_q, key_start_d;
    logic [3:0] key_coin_q, key_coin_d;

    logic [3:0] key_up_w, key_down_w, key_left_w, key_right_w, key_fire_w;

    logic [15:0]        joy_or;
    logic [15:0]        joy_own;
    logic [15:0]        joy_sel;
    logic [PLAYERS-1:0] src_up, src_down, src_left, src_right;
    logic [PLAYERS-1:0] src_fire, src_start, src_coin;

    logic [PLAYERS-1:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic [PLAYERS-1:0] fire_q, fire_d, start_q, start_d, coin_q, coin_d;
    logic [PLAYERS-1:0] coin_prev_q, coin_prev_d;
    logic [PLAYERS-1:0] af_held_q, af_held_d;
    logic [CoinW-1:0]   coin_cnt_q [PLAYERS];
    logic [CoinW-1:0]   coin_cnt_d [PLAYERS];
    logic [AfW-1:0]     af_cnt_q [PLAYERS];
    logic [AfW-1:0]     af_cnt_d [PLAYERS];

    assign ps2_event   = ctrl_io.ps2_key[10] != old_toggle_q;
    assign ps2_pressed = ctrl_io.ps2_key[9];
    assign ps2_ext     = ctrl_io.ps2_key[8];
    assign ps2_code    = ctrl_io.ps2_key[7:0];

    assign key_up_w    = {2'b00, key_up_q};
    assign key_down_w  = {2'b00, key_down_q};
    assign key_left_w  = {2'b00, key_left_q};
    assign key_right_w = {2'b00, key_right_q};
    assign key_fire_w  = {2'b00, key_fire_q};

    // Decode a PS/2 event into the held-key state; arrows ignore the E0 flag.
    always_comb begin
        key_up_d    = key_up_q;
        key_down_d  = key_down_q;
        key_left_d  = key_left_q;
        key_right_d = key_right_q;
        key_fire_d  = key_fire_q;
        key_start_d = key_start_q;
        key_coin_d  = key_coin_q;
        if (ps2_event) begin
            case (ps2_code)
                8'h75: key_up_d[0]    = ps2_pressed;
                8'h72: key_down_d[0]  = ps2_pressed;
                8'h6B: key_left_d[0]  = ps2_pressed;
                8'h74: key_right_d[0] = ps2_pressed;
                default: begin
                    if (!ps2_ext) begin
                        case (ps2_code)
                            8'h29, 8'h14: key_fire_d[0]  = ps2_pressed;
                            8'h2D:        key_up_d[1]    = ps2_pressed;
                            8'h2B:        key_down_d[1]  = ps2_pressed;
                            8'h23:        key_left_d[1]  = ps2_pressed;
                            8'h34:        key_right_d[1] = ps2_pressed;
                            8'h1C:        key_fire_d[1]  = ps2_pressed;
                            8'h16, 8'h05: key_start_d[0] = ps2_pressed;
                            8'h1E, 8'h06: key_start_d[1] = ps2_pressed;
                            8'h26:        key_start_d[2] = ps2_pressed;
                            8'h25:        key_start_d[3] = ps2_pressed;
                            8'h2E:        key_coin_d[0]  = ps2_pressed;
                            8'h36:        key_coin_d[1]  = ps2_pressed;
                            8'h3D:        key_coin_d[2]  = ps2_pressed;
                            8'h3E:        key_coin_d[3]  = ps2_pressed;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Merge keys with joysticks; shared mode ORs all sticks for directions/fire only.
    always_comb begin
        joy_or    = '0;
        joy_own   = '0;
        joy_sel   = '0;
        src_up    = '0;
        src_down  = '0;
        src_left  = '0;
        src_right = '0;
        src_fire  = '0;
        src_start = '0;
        src_coin  = '0;
        for (int p = 0; p < int'(PLAYERS); p++) begin
            joy_or = joy_or | ctrl_io.joy_in[16*p +: 16];
        end
        for (int p = 0; p < int'(PLAYERS); p++) begin
            joy_own      = ctrl_io.joy_in[16*p +: 16];
            joy_sel      = ctrl_io.joy_share ? joy_or : joy_own;
            src_right[p] = joy_sel[0] | key_right_w[p];
            src_left[p]  = joy_sel[1] | key_left_w[p];
            src_down[p]  = joy_sel[2] | key_down_w[p];
            src_up[p]    = joy_sel[3] | key_up_w[p];
            src_fire[p]  = joy_sel[4] | key_fire_w[p];
            src_start[p] = joy_own[5] | key_start_q[p];
            src_coin[p]  = joy_own[7] | key_coin_q[p];
        end
    end

    // Output next-state: opposite-direction cleaning, coin pulse timer, autofire phase.
    always_comb begin
        up_d        = src_up & ~src_down;
        down_d      = src_down & ~src_up;
        left_d      = src_left & ~src_right;
        right_d     = src_right & ~src_left;
        start_d     = src_start;
        coin_prev_d = src_coin;
        coin_d      = '0;
        fire_d      = '0;
        af_held_d   = '0;
        for (int p = 0; p < int'(PLAYERS); p++) begin
            // A rise only starts a pulse when the previous one has fully ended.
            if (coin_cnt_q[p] != '0) begin
                coin_cnt_d[p] = coin_cnt_q[p] - CoinW'(1);
            end else if (src_coin[p] && !coin_prev_q[p]) begin
                coin_cnt_d[p] = CoinLoad;
            end else begin
                coin_cnt_d[p] = '0;
            end
            coin_d[p] = coin_cnt_d[p] != '0;

            // Clearing the held flag while disabled makes re-enable act as a fresh press.
            af_cnt_d[p] = '0;
            if (!ctrl_io.autofire_en) begin
                fire_d[p] = src_fire[p];
            end else if (!src_fire[p]) begin
                fire_d[p] = 1'b0;
            end else if (!af_held_q[p]) begin
                fire_d[p]    = 1'b1;
                af_held_d[p] = 1'b1;
            end else if (af_cnt_q[p] == AfLast) begin
                fire_d[p]    = ~fire_q[p];
                af_held_d[p] = 1'b1;
            end else begin
                fire_d[p]    = fire_q[p];
                af_held_d[p] = 1'b1;
                af_cnt_d[p]  = af_cnt_q[p] + AfW'(1);
            end
        end
    end

    // State and output registers; reset re-syncs the toggle so no event fires on exit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_toggle_q <= ctrl_io.ps2_key[10];
            key_up_q     <= '0;
            key_down_q   <= '0;
            key_left_q   <= '0;
            key_right_q  <= '0;
            key_fire_q   <= '0;
            key_start_q  <= '0;
            key_coin_q   <= '0;
            up_q         <= '0;
            down_q       <= '0;
            left_q       <= '0;
            right_q      <= '0;
            fire_q       <= '0;
            start_q      <= '0;
            coin_q       <= '0;
            coin_prev_q  <= '0;
            af_held_q    <= '0;
            for (int p = 0; p < int'(PLAYERS); p++) begin
                coin_cnt_q[p] <= '0;
                af_cnt_q[p]   <= '0;
            end
        end else begin
            old_toggle_q <= ctrl_io.ps2_key[10];
            key_up_q     <= key_up_d;
            key_down_q   <= key_down_d;
            key_left_q   <= key_left_d;
            key_right_q  <= key_right_d;
            key_fire_q   <= key_fire_d;
            key_start_q  <= key_start_d;
            key_coin_q   <= key_coin_d;
            up_q         <= up_d;
            down_q       <= down_d;
            left_q       <= left_d;
            right_q      <= right_d;
            fire_q       <= fire_d;
            start_q      <= start_d;
            coin_q       <= coin_d;
            coin_prev_q  <= coin_prev_d;
            af_held_q    <= af_held_d;
            for (int p = 0; p < int'(PLAYERS); p++) begin
                coin_cnt_q[p] <= coin_cnt_d[p];
                af_cnt_q[p]   <= af_cnt_d[p];
            end
        end
    end

    assign ctrl_io.up    = up_q;
    assign ctrl_io.down  = down_q;
    assign ctrl_io.left  = left_q;
    assign ctrl_io.right = right_q;
    assign ctrl_io.fire  = fire_q;
    assign ctrl_io.start = start_q;
    assign ctrl_io.coin  = coin_q;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus random key/joystick
// traffic, every cycle compared against a time-based reference model.
module tb_arcade_input_mapper;
    localparam int unsigned PLAYERS      = 2;
    localparam int unsigned COIN_PULSE   = 16;
    localparam int unsigned AUTOFIRE_DIV = 4;
    localparam int          NP           = int'(PLAYERS);

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    arcade_input_mapper_if #(.PLAYERS(PLAYERS)) bus ();

    arcade_input_mapper #(
        .PLAYERS      (PLAYERS),
        .COIN_PULSE   (COIN_PULSE),
        .AUTOFIRE_DIV (AUTOFIRE_DIV)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ctrl_io (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference model: key table indexed group*4+player
    // (groups: 0 up,1 down,2 left,3 right,4 fire,5 start,6 coin).
    bit          m_key [28];
    bit          m_tog;
    int          cyc = 0;
    bit          m_coin_prev [4];
    int          m_coin_start [4];
    bit          m_holding [4];
    int          m_hold_start [4];
    logic [31:0] exp_vec;

    function automatic int key_index(input logic ext, input logic [7:0] code);
        case (code)
            8'h75: return 0;
            8'h72: return 4;
            8'h6B: return 8;
            8'h74: return 12;
            default: ;
        endcase
        if (ext) return -1;
        case (code)
            8'h29, 8'h14: return 16;
            8'h2D: return 1;
            8'h2B: return 5;
            8'h23: return 9;
            8'h34: return 13;
            8'h1C: return 17;
            8'h16, 8'h05: return 20;
            8'h1E, 8'h06: return 21;
            8'h26: return 22;
            8'h25: return 23;
            8'h2E: return 24;
            8'h36: return 25;
            8'h3D: return 26;
            8'h3E: return 27;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 28; i++) m_key[i] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            m_coin_prev[p]  = 1'b0;
            m_coin_start[p] = -1000;
            m_holding[p]    = 1'b0;
        end
    endtask

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_edge();
        logic [15:0]   jor, own, jd;
        bit            su, sd, sl, sr, sf, sc;
        logic [NP-1:0] eu, ed, el, er, ef, es, ec;
        int            idx;
        cyc++;
        eu = '0; ed = '0; el = '0; er = '0; ef = '0; es = '0; ec = '0;
        if (reset) begin
            model_clear();
            m_tog = bus.ps2_key[10];
        end else begin
            jor = '0;
            for (int p = 0; p < NP; p++) jor = jor | bus.joy_in[16*p +: 16];
            for (int p = 0; p < NP; p++) begin
                own = bus.joy_in[16*p +: 16];
                jd  = bus.joy_share ? jor : own;
                sr  = jd[0] | m_key[12+p];
                sl  = jd[1] | m_key[8+p];
                sd  = jd[2] | m_key[4+p];
                su  = jd[3] | m_key[p];
                sf  = jd[4] | m_key[16+p];
                eu[p] = su && !sd;
                ed[p] = sd && !su;
                el[p] = sl && !sr;
                er[p] = sr && !sl;
                es[p] = own[5] | m_key[20+p];
                sc    = own[7] | m_key[24+p];
                // New pulse only if the old one was no longer showing last cycle.
                if (sc && !m_coin_prev[p] && (cyc - m_coin_start[p]) > int'(COIN_PULSE))
                    m_coin_start[p] = cyc;
                m_coin_prev[p] = sc;
                ec[p] = (cyc - m_coin_start[p]) < int'(COIN_PULSE);
                if (!bus.autofire_en) begin
                    ef[p] = sf;
                    m_holding[p] = 1'b0;
                end else if (!sf) begin
                    ef[p] = 1'b0;
                    m_holding[p] = 1'b0;
                end else begin
                    if (!m_holding[p]) begin
                        m_holding[p]    = 1'b1;
                        m_hold_start[p] = cyc;
                    end
                    ef[p] = (((cyc - m_hold_start[p]) / int'(AUTOFIRE_DIV)) % 2) == 0;
                end
            end
            if (bus.ps2_key[10] != m_tog) begin
                idx = key_index(bus.ps2_key[8], bus.ps2_key[7:0]);
                if (idx >= 0) m_key[idx] = bus.ps2_key[9];
            end
            m_tog = bus.ps2_key[10];
        end
        exp_vec = 32'({eu, ed, el, er, ef, es, ec});
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({bus.up, bus.down, bus.left, bus.right, bus.fire, bus.start, bus.coin});
    endfunction

    task automatic tick(input string tag);
        @(posedge clk_sys);
        model_edge();
        #1;
        check(tag, dut_vec(), exp_vec);
    endtask

    task automatic send_key(input bit ext, input logic [7:0] code, input bit pressed);
        bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    endtask

    logic [7:0] codes [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h2D, 8'h2B,
                               8'h23, 8'h34, 8'h1C, 8'h16, 8'h05, 8'h1E, 8'h06, 8'h26,
                               8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h11, 8'h5A, 8'h76};

    initial begin
        int          high_cnt, rises;
        logic        prev_c;
        logic [19:0] pattern;

        model_clear();
        bus.ps2_key     = 11'h400;
        bus.joy_in      = '0;
        bus.joy_share   = 1'b0;
        bus.autofire_en = 1'b0;
        m_tog           = 1'b1;

        // Reset with toggle high, then release: nothing latched.
        reset = 1'b1;
        repeat (3) tick("reset");
        reset = 1'b0;
        repeat (2) tick("post_reset");
        check("post_reset_zero", dut_vec(), 32'h0);

        // Extended arrow up: key state at first edge, output one edge later.
        send_key(1'b1, 8'h75, 1'b1);
        tick("arrow_evt");
        check("up0_one_clk", 32'(bus.up[0]), 32'h0);
        tick("arrow_out");
        check("up0_two_clk", 32'(bus.up[0]), 32'h1);
        send_key(1'b1, 8'h75, 1'b0);
        tick("arrow_rel");
        tick("arrow_rel2");
        check("up0_released", 32'(bus.up[0]), 32'h0);

        // Joystick cleaning and one-clock latency.
        bus.joy_in[15:0] = 16'h000C;
        tick("joy_updown");
        check("joy_updown_clean", 32'({bus.up[0], bus.down[0]}), 32'h0);
        bus.joy_in[15:0] = 16'h0008;
        tick("joy_up");
        check("joy_up_1clk", 32'(bus.up[0]), 32'h1);

        // Shared directions/fire; start stays per player.
        bus.joy_in    = '0;
        bus.joy_share = 1'b1;
        bus.joy_in[31:16] = 16'h0010;
        tick("share_fire");
        check("share_fire_both", 32'(bus.fire), 32'h3);
        bus.joy_in[31:16] = 16'h0020;
        tick("share_start");
        check("share_start_own", 32'(bus.start), 32'h2);
        bus.joy_in    = '0;
        bus.joy_share = 1'b0;
        tick("share_off");

        // Back-to-back events on consecutive cycles.
        send_key(1'b1, 8'h6B, 1'b1);
        tick("b2b_a");
        send_key(1'b0, 8'h2D, 1'b1);
        tick("b2b_b");
        tick("b2b_c");
        check("b2b_both", 32'({bus.left[0], bus.up[1]}), 32'h3);
        send_key(1'b1, 8'h6B, 1'b0);
        tick("b2b_rel_a");
        send_key(1'b0, 8'h2D, 1'b0);
        tick("b2b_rel_b");
        tick("b2b_rel_c");

        // Coin key held 100 clocks: one pulse of COIN_PULSE.
        send_key(1'b0, 8'h2E, 1'b1);
        high_cnt = 0; rises = 0; prev_c = 1'b0;
        repeat (100) begin
            tick("coin_hold");
            if (bus.coin[0]) high_cnt++;
            if (bus.coin[0] && !prev_c) rises++;
            prev_c = bus.coin[0];
        end
        check("coin_len", 32'(high_cnt), 32'(COIN_PULSE));
        check("coin_one_pulse", 32'(rises), 32'h1);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (3) tick("coin_rel");

        // Second press gives a pulse; re-press 5 clocks in does not extend it.
        send_key(1'b0, 8'h2E, 1'b1);
        high_cnt = 0; rises = 0; prev_c = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick("coin_again");
            if (bus.coin[0]) high_cnt++;
            if (bus.coin[0] && !prev_c) rises++;
            prev_c = bus.coin[0];
            if (i == 2) send_key(1'b0, 8'h2E, 1'b0);
            if (i == 4) send_key(1'b0, 8'h2E, 1'b1);
        end
        check("coin_noext_len", 32'(high_cnt), 32'(COIN_PULSE));
        check("coin_noext_pulses", 32'(rises), 32'h1);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (2) tick("coin_rel2");

        // Autofire pattern for a 20-clock hold.
        bus.autofire_en   = 1'b1;
        bus.joy_in[15:0]  = 16'h0010;
        pattern = '0;
        for (int i = 0; i < 20; i++) begin
            tick("af_hold");
            pattern = {pattern[18:0], bus.fire[0]};
        end
        check("af_pattern", 32'(pattern), 32'h000F0F0F);
        bus.joy_in[15:0] = 16'h0000;
        tick("af_rel");
        check("af_rel_low", 32'(bus.fire[0]), 32'h0);
        bus.autofire_en = 1'b0;
        tick("af_off");

        // Reset mid coin pulse with P1 fire key held.
        send_key(1'b0, 8'h1C, 1'b1);
        tick("rst_k1");
        send_key(1'b0, 8'h2E, 1'b1);
        tick("rst_k2");
        tick("rst_k3");
        tick("rst_k4");
        reset = 1'b1;
        tick("rst_mid");
        check("rst_mid_zero", dut_vec(), 32'h0);
        reset = 1'b0;
        repeat (3) tick("rst_after");
        check("rst_key_cleared", 32'(bus.fire[1]), 32'h0);
        send_key(1'b0, 8'h1C, 1'b1);
        tick("rst_make");
        tick("rst_make2");
        check("rst_new_make", 32'(bus.fire[1]), 32'h1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                send_key(1'($urandom_range(3) == 0), codes[$urandom_range(23)],
                         1'($urandom_range(1)));
            end
            if ($urandom_range(7) == 0) begin
                for (int p = 0; p < NP; p++)
                    bus.joy_in[16*p +: 16] = 16'($urandom & $urandom & 32'h00BF);
            end
            if ($urandom_range(63) == 0) bus.joy_share = ~bus.joy_share;
            if ($urandom_range(127) == 0) bus.autofire_en = ~bus.autofire_en;
            reset = ($urandom_range(499) == 0);
            tick("random");
        end
        reset = 1'b0;
        tick("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
